vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the 640x480 display path. It produces the pixel coordinates `x`/`y` that feed the multi-cycle in-circle comparator, along with the sync and blanking signals for the VGA output stage. Pixel coordinates advance once every `TICK_DIV` clocks, so the 4-cycle comparator sees each coordinate pair held for a full evaluation.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible columns
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `TICK_DIV`, 4, clocks per pixel; must be ≥ 4 to match comparator cadence

Ports:
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `x`  out  10  current column counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- `y`  out  10  current line counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- `pixel_tick`  out  1  one-clock pulse on the last clock of each pixel period
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high while (x, y) is in the visible area
- `frame_start`  out  1  one-clock pulse concurrent with the tick that wraps (799,524) to (0,0)

## Operation
- Prescaler `div` counts 0..TICK_DIV-1 and wraps. `pixel_tick` = 1 while `div == TICK_DIV-1`.
- On a clock edge with `pixel_tick` high:
  - `x` increments.
  - At `x == H_TOTAL-1`, `x` wraps to 0 and `y` increments.
  - At `y == V_TOTAL-1` together with the `x` wrap, `y` wraps to 0.
- `x` and `y` change only on that edge, so each value is held exactly TICK_DIV clocks.
- `hsync` = 0 iff H_DISPLAY+H_FP ≤ x ≤ H_DISPLAY+H_FP+H_SYNC-1, i.e. 656..751.
- `vsync` = 0 iff V_DISPLAY+V_FP ≤ y ≤ V_DISPLAY+V_FP+V_SYNC-1, i.e. 490..491.
- `video_on` = (x < H_DISPLAY) && (y < V_DISPLAY).
- `hsync`, `vsync` and `video_on` are registered. They are computed from next-state counters so they change on the same edge as `x`/`y` and always describe the coordinate currently presented.
- Counter widths: 10 bits unsigned. No value outside 0..799 / 0..524 is ever driven.

## Timing
- Reset values:
  - `x` = 0, `y` = 0, `div` = 0
  - `pixel_tick` = 0, `frame_start` = 0
  - `hsync` = 1, `vsync` = 1
  - `video_on` = 0. This is forced during reset only; on the first clock after release it becomes 1 to reflect (0,0).
- After `reset` deasserts, the first `pixel_tick` occurs TICK_DIV-1 clocks later, i.e. with `div` 0→3 for TICK_DIV = 4.
- Line period: 800×TICK_DIV clocks. Frame period: 525×800×TICK_DIV clocks (1,680,000 at TICK_DIV = 4).
- Comparator pairing: when this block and the comparator leave reset on the same edge, each comparator INIT samples a freshly presented (x, y). The resulting `in_circle` appears TICK_DIV clocks later, i.e. one pixel late relative to the raw outputs.
- Reset mid-frame: takes effect on the next edge. All counters and outputs return to their reset values and any in-progress tick is discarded.
- Simultaneous x-wrap and y-wrap: `frame_start` and `pixel_tick` are both high in that cycle. On the following edge `x` = 0, `y` = 0, `vsync` = 1.

## Configuration
- Macro: `VGA_SYNC_ALIGN_EN`.
- Defined: `hsync`, `vsync` and `video_on` pass through an extra one-pixel delay stage that advances on `pixel_tick`. The stage resets to 1/1/0. This aligns them with comparator `in_circle` for the same coordinate. `x`, `y`, `pixel_tick` and `frame_start` are not delayed.
- Undefined: no delay stage; sync and blanking align with raw `x`/`y` as described above.

## Test plan
- Reset hold then release, TICK_DIV = 4:
  - `x`/`y` stay 0 for 4 clocks.
  - `pixel_tick` high on clock 3 only.
  - `x` = 1 at clock 4.
- Run one line:
  - `hsync` falls when `x` becomes 656 and rises when `x` becomes 752.
  - `video_on` falls when `x` becomes 640.
  - `x` wraps 799→0 while `y` goes 0→1.
- Run a full frame:
  - `vsync` is low exactly for `y` = 490 and 491.
  - A single `frame_start` pulse occurs at 1,679,999 clocks after release.
  - `y` wraps 524→0.
- Assert `reset` for 1 clock at (x=300, y=200):
  - Next edge gives `x` = 0, `y` = 0, `hsync` = `vsync` = 1, `pixel_tick` = 0.
  - Counting restarts with the first tick 3 clocks later.
- Closed loop with the comparator:
  - (320,240) yields `in_circle` = 1.
  - (420,240) yields 0 (100² not < 10000).
  - (419,240) yields 1.
  - With `VGA_SYNC_ALIGN_EN` defined, `video_on` lags `x` by exactly 4 clocks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel prescaler, x/y counters, registered sync/blanking.
// Optional macro VGA_SYNC_ALIGN_EN adds a one-pixel delay on hsync/vsync/video_on.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]       HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]       HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]       VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Decoded from next-state counters so the flops line up with the x/y they describe.
    always_comb begin
        hsync_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_dly_q, hsync_dly_d;
    logic vsync_dly_q, vsync_dly_d;
    logic video_on_dly_q, video_on_dly_d;

    // Holds the previous pixel's decode so it matches the comparator's one-pixel latency.
    always_comb begin
        hsync_dly_d    = tick ? hsync_q    : hsync_dly_q;
        vsync_dly_d    = tick ? vsync_q    : vsync_dly_q;
        video_on_dly_d = tick ? video_on_q : video_on_dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_dly_q    <= 1'b1;
            vsync_dly_q    <= 1'b1;
            video_on_dly_q <= 1'b0;
        end else begin
            hsync_dly_q    <= hsync_dly_d;
            vsync_dly_q    <= vsync_dly_d;
            video_on_dly_q <= video_on_dly_d;
        end
    end

    assign hsync    = hsync_dly_q;
    assign vsync    = vsync_dly_q;
    assign video_on = video_on_dly_q;
`else
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_tick  = tick;
    assign frame_start = tick && (x_q == H_LAST) && (y_q == V_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced raster (25x15 pixels, 4 clocks/pixel).
// Expected outputs come from the clock count since reset release.
module tb_vga_sync_gen;
    localparam int HD = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VD = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int TD = 4;
    localparam int HT = HD + HFP + HS + HBP;
    localparam int VT = VD + VFP + VS + VBP;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       vo;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x, y;
    logic       pixel_tick, hsync, vsync, video_on, frame_start;

    int   errors = 0;
    int   checks = 0;
    int   cnt = 0;
    bit   in_rst = 1'b1;
    bit   done = 1'b0;
    int   fs_seen = 0;
    exp_t exp_q[$];

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .pixel_tick(pixel_tick),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Sync/blank decode of a pixel index, straight from the raster rules.
    function automatic void decode(input int p, output logic hs, output logic vs, output logic vo);
        int px, py;
        px = p % HT;
        py = (p / HT) % VT;
        hs = !(px >= HD + HFP && px < HD + HFP + HS);
        vs = !(py >= VD + VFP && py < VD + VFP + VS);
        vo = (px < HD) && (py < VD);
    endfunction

    function automatic exp_t model(input bit r, input int c);
        exp_t e;
        int   p;
        p      = c / TD;
        e.x    = 10'(p % HT);
        e.y    = 10'((p / HT) % VT);
        e.tick = !r && ((c % TD) == TD - 1);
        e.fs   = e.tick && (int'(e.x) == HT - 1) && (int'(e.y) == VT - 1);
`ifdef VGA_SYNC_ALIGN_EN
        if (r || p == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.vo = 1'b0;
        end else begin
            decode(p - 1, e.hs, e.vs, e.vo);
        end
`else
        decode(p, e.hs, e.vs, e.vo);
        if (r) e.vo = 1'b0;
`endif
        return e;
    endfunction

    task automatic step(input logic r);
        @(negedge clk);
        reset = r;
        @(posedge clk);
        if (r) cnt = 0;
        else   cnt = cnt + 1;
        in_rst = r;
        exp_q.push_back(model(r, cnt));
    endtask

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: one line per popped transaction, field-by-field compare.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("x", int'(x), int'(e.x));
                check("y", int'(y), int'(e.y));
                check("pixel_tick", int'(pixel_tick), int'(e.tick));
                check("frame_start", int'(frame_start), int'(e.fs));
                check("hsync", int'(hsync), int'(e.hs));
                check("vsync", int'(vsync), int'(e.vs));
                check("video_on", int'(video_on), int'(e.vo));
                if (frame_start === 1'b1) fs_seen = fs_seen + 1;
                $display("t=%0t rst=%0b x=%0d y=%0d tick=%0b fs=%0b hs=%0b vs=%0b vo=%0b",
                         $time, reset, x, y, pixel_tick, frame_start, hsync, vsync, video_on);
            end
        end
    end

    initial begin
        int run_len;
        repeat (3) step(1'b1);
        // Two complete frames uninterrupted: exactly two frame_start pulses expected.
        fs_seen = 0;
        repeat (2 * HT * VT * TD) step(1'b0);
        @(posedge clk);
        #2;
        check("frame_start_count", fs_seen, 2);
        // Mid-frame single-cycle reset, then random run/reset phases.
        step(1'b1);
        for (int i = 0; i < 12; i++) begin
            run_len = int'($urandom_range(1, 1800));
            repeat (run_len) step(1'b0);
            repeat (int'($urandom_range(1, 3))) step(1'b1);
        end
        repeat (50) step(1'b0);
        @(posedge clk);
        #2;
        done = 1'b1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
